// File: rtl/flap_input_ctrl_if.sv
// Purpose: key-event and flap-command bundle around flap_input_ctrl.
//   master: key-event source (PS/2 decoder side); receives flap status.
//   slave : flap_input_ctrl; consumes key events, drives flap/key_held/flap_count.
// Signals:
//   key_valid  1-cycle strobe, key_make/key_code valid this cycle
//   key_make   1 = make (press), 0 = break (release)
//   key_code   8-bit scan code
//   flap       1-cycle flap pulse to the bird
//   key_held   flap key currently held
//   flap_count 16-bit wrapping count of issued flaps
interface flap_input_ctrl_if;
    logic        key_valid;
    logic        key_make;
    logic [7:0]  key_code;
    logic        flap;
    logic        key_held;
    logic [15:0] flap_count;

    modport master (
        output key_valid, key_make, key_code,
        input  flap, key_held, flap_count
    );

    modport slave (
        input  key_valid, key_make, key_code,
        output flap, key_held, flap_count
    );
endinterface

// File: rtl/flap_input_ctrl.sv
// Purpose: turns keyboard scan events into the single-cycle flap command for the bird.
//   Detects the flap key, rejects typematic repeats, enforces a minimum spacing of
//   GAP_CYCLES between flaps (one press may be held pending during the gap) and counts
//   issued flaps.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high; dominates all inputs
//   bus    flap_input_ctrl_if.slave (key_valid/key_make/key_code in;
//          flap/key_held/flap_count out, all registered)
// Optional feature: define FLAP_AUTOREPEAT_EN to issue a repeat flap every
//   REPEAT_CYCLES while the key stays held. Without it, holding the key gives one flap.
module flap_input_ctrl #(
    parameter logic [7:0]  FLAP_CODE     = 8'h29,
    parameter int unsigned GAP_CYCLES    = 6_250_000,
    parameter int unsigned REPEAT_CYCLES = 12_500_000,
    parameter int unsigned CNT_W         = 24
) (
    input  logic                clk,
    input  logic                reset,
    flap_input_ctrl_if.slave    bus
);

    localparam int unsigned     CNT_WIDTH = 16;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    // Reject configurations the counters cannot represent.
    if (GAP_CYCLES < 2 || REPEAT_CYCLES < GAP_CYCLES || CNT_W < 2 || CNT_W > 32 ||
        64'(REPEAT_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_cfg
        $error("flap_input_ctrl: invalid GAP_CYCLES/REPEAT_CYCLES/CNT_W combination");
    end

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_COOLDOWN = 1'b1
    } state_e;

    state_e                 state_q,      state_d;
    logic [CNT_W-1:0]       gap_cnt_q,    gap_cnt_d;
    logic                   pending_q,    pending_d;
    logic                   flap_q,       flap_d;
    logic                   key_held_q,   key_held_d;
    logic [CNT_WIDTH-1:0]   flap_count_q, flap_count_d;

    logic code_hit;
    logic press;
    logic release_ev;
    logic rep_req;
    logic req;
    logic fire;

    // Event decode: only valid events carrying the flap key's code matter.
    assign code_hit   = bus.key_valid && (bus.key_code == FLAP_CODE);
    assign press      = code_hit &&  bus.key_make && !key_held_q;
    assign release_ev = code_hit && !bus.key_make;
    assign req        = press || rep_req;

`ifdef FLAP_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;

    // Cycles since the last flap while held; saturates at REP_LAST until a flap restarts it.
    assign rep_req = key_held_q && !release_ev && (rep_cnt_q == REP_LAST);

    always_comb begin : rep_next
        rep_cnt_d = rep_cnt_q;
        if (release_ev) begin
            rep_cnt_d = '0;
        end else if (key_held_q && (rep_cnt_q != REP_LAST)) begin
            rep_cnt_d = rep_cnt_q + CNT_W'(1);
        end
        if (fire) begin
            rep_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin : rep_reg
        if (reset) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end
`else
    assign rep_req = 1'b0;
`endif

    // Next-state and output logic.
    always_comb begin : next_state
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        pending_d    = pending_q;
        flap_d       = 1'b0;
        key_held_d   = key_held_q;
        flap_count_d = flap_count_q;
        fire         = 1'b0;

        if (code_hit) begin
            key_held_d = bus.key_make;
        end

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    fire = 1'b1;
                end
            end
            S_COOLDOWN: begin
                if (gap_cnt_q != '0) begin
                    // Still inside the gap: a request is parked (1-deep).
                    gap_cnt_d = gap_cnt_q - CNT_W'(1);
                    if (req) begin
                        pending_d = 1'b1;
                    end
                end else if (pending_q || req) begin
                    // Gap has elapsed: pending flap and a same-cycle press merge.
                    fire = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Issuing a flap: pulse, count, and restart the gap.
        if (fire) begin
            flap_d       = 1'b1;
            pending_d    = 1'b0;
            gap_cnt_d    = GAP_LOAD;
            state_d      = S_COOLDOWN;
            flap_count_d = flap_count_q + CNT_WIDTH'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin : state_reg
        if (reset) begin
            state_q      <= S_IDLE;
            gap_cnt_q    <= '0;
            pending_q    <= 1'b0;
            flap_q       <= 1'b0;
            key_held_q   <= 1'b0;
            flap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            pending_q    <= pending_d;
            flap_q       <= flap_d;
            key_held_q   <= key_held_d;
            flap_count_q <= flap_count_d;
        end
    end

    assign bus.flap       = flap_q;
    assign bus.key_held   = key_held_q;
    assign bus.flap_count = flap_count_q;

endmodule
